// File: rtl/instr_encode_loader_if.sv
// Request and instruction-memory write channels of instr_encode_loader.
//   in_valid/in_ready  : request handshake, transfer when both high
//   in_cls..in_imm     : structured instruction request fields
//   imem_we/imem_ready : write handshake, transfer when both high
//   imem_addr          : word-aligned byte address of the write
//   imem_wdata         : encoded RV32I word
// Modport slave is the loader's view; master is the requester/memory side.
interface instr_encode_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cls;
   logic [2:0]  in_func3;
   logic        in_func7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        imem_we;
   logic        imem_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport slave (
      input  in_valid, in_cls, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_cls, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encode_loader.sv
// Packs structured RV32I instruction requests into 32-bit words and writes them
// sequentially into instruction memory, one session at a time.
// Ports:
//   i_clk            : clock, rising edge
//   i_rst            : synchronous active-high reset
//   i_start          : pulse, opens a load session (IDLE only)
//   i_finish         : pulse, closes the session once the buffer drains (LOAD/FULL only)
//   bus              : request and imem write channels (slave modport)
//   o_busy           : state != IDLE
//   o_done           : one-cycle pulse while in DONE
//   o_err            : sticky, an illegal request was seen this session
//   o_words_written  : completed memory writes this session
module instr_encode_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_finish,
   instr_encode_loader_if.slave  bus,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [15:0]           o_words_written
);

   localparam logic [15:0] LastCnt = 16'(DEPTH - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StFull, StDrain, StDone} state_t;

   state_t      r_state;
   logic        r_buf_valid;
   logic [31:0] r_buf_data;
   logic [31:0] r_addr;
   logic [15:0] r_cnt;
   logic [15:0] r_words;
   logic        r_err;

   logic        w_legal;
   logic [31:0] w_enc;
   logic        w_accept;
   logic        w_xfer;

   // Single-entry buffer: a new word may enter in the same cycle the old one leaves.
   assign bus.in_ready   = (r_state == StLoad) && (!r_buf_valid || bus.imem_ready);
   assign w_accept       = bus.in_valid && bus.in_ready;
   assign w_xfer         = r_buf_valid && bus.imem_ready;
   assign bus.imem_we    = r_buf_valid;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_buf_data;

   assign o_busy          = (r_state != StIdle);
   assign o_done          = (r_state == StDone);
   assign o_err           = r_err;
   assign o_words_written = r_words;

   always_comb begin
      w_legal = 1'b1;
      w_enc   = '0;
      case (bus.in_cls)
         4'd0: w_enc = {1'b0, bus.in_func7, 5'b0, bus.in_rs2, bus.in_rs1, bus.in_func3, bus.in_rd,
                        7'h33};
         4'd1: begin
            // Shift-immediates carry the SRA/SRL select in bit 30 and a 5-bit shamt.
            if (bus.in_func3 == 3'b001 || bus.in_func3 == 3'b101) begin
               w_enc = {1'b0, bus.in_func7, 5'b0, bus.in_imm[4:0], bus.in_rs1, bus.in_func3,
                        bus.in_rd, 7'h13};
            end else begin
               w_enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, 7'h13};
            end
         end
         4'd2: w_enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, 7'h03};
         4'd3: w_enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func3, bus.in_imm[4:0],
                        7'h23};
         4'd4: begin
            w_legal = (bus.in_func3[2:1] != 2'b01);
            w_enc   = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                       bus.in_imm[4:1], bus.in_imm[11], 7'h63};
         end
         4'd5: w_enc = {bus.in_imm[31:12], bus.in_rd, 7'h37};
         4'd6: w_enc = {bus.in_imm[31:12], bus.in_rd, 7'h17};
         4'd7: w_enc = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                        bus.in_rd, 7'h6F};
         4'd8: w_enc = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'h67};
         default: w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_buf_valid <= 1'b0;
         r_buf_data  <= '0;
         r_addr      <= BASE_ADDR;
         r_cnt       <= '0;
         r_words     <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_addr  <= r_addr + 32'd4;
            r_words <= r_words + 16'd1;
         end
         if (w_accept && w_legal) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= w_enc;
            r_cnt       <= r_cnt + 16'd1;
         end else if (w_xfer) begin
            r_buf_valid <= 1'b0;
         end
         // Illegal requests complete the handshake but are dropped.
         if (w_accept && !w_legal) begin
            r_err <= 1'b1;
         end
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_state <= StLoad;
                  r_addr  <= BASE_ADDR;
                  r_cnt   <= '0;
                  r_words <= '0;
                  r_err   <= 1'b0;
               end
            end
            StLoad: begin
               if (i_finish) begin
                  r_state <= StDrain;
               end else if (w_accept && w_legal && r_cnt == LastCnt) begin
                  r_state <= StFull;
               end
            end
            StFull: begin
               if (i_finish) begin
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if (!r_buf_valid) begin
                  r_state <= StDone;
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encode_loader.sv
module tb_instr_encode_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        finish;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] words;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] rx_addr_q[$];
   logic [31:0] rx_data_q[$];
   int          rx_cyc_q[$];
   int          cyc = 0;
   logic [31:0] model_addr = 32'h0;

   instr_encode_loader_if bus ();

   instr_encode_loader #(
      .BASE_ADDR (32'h0000_0000),
      .DEPTH     (4)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_start         (start),
      .i_finish        (finish),
      .bus             (bus),
      .o_busy          (busy),
      .o_done          (done),
      .o_err           (err),
      .o_words_written (words)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every completed memory write; sampled mid-cycle, ahead of the edge that commits it.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
         rx_addr_q.push_back(bus.imem_addr);
         rx_data_q.push_back(bus.imem_wdata);
         rx_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_req(input logic [3:0] cls, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic [31:0] exp_word, input bit legal,
                           output bit accepted);
      bus.in_valid = 1'b1;
      bus.in_cls   = cls;
      bus.in_func3 = f3;
      bus.in_func7 = f7;
      bus.in_rd    = rd;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      bus.in_imm   = imm;
      accepted     = 1'b0;
      for (int i = 0; i < 10 && !accepted; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (accepted && legal) begin
         exp_addr_q.push_back(model_addr);
         exp_data_q.push_back(exp_word);
         model_addr = model_addr + 32'd4;
      end
   endtask

   task automatic open_session();
      start = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      model_addr = 32'h0;
   endtask

   task automatic close_session(output int n_done, output int first_done);
      finish = 1'b1;
      @(posedge clk);
      #1;
      finish     = 1'b0;
      n_done     = 0;
      first_done = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = i;
         end
         if (busy === 1'b0) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (words !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words); end
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.imem_we); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
      rst = 1'b0;
      // finish in IDLE must be ignored
      finish = 1'b1;
      @(posedge clk);
      #1;
      finish = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_finish: busy got %b want 0", busy); end
   endtask

   task automatic test_start_priority();
      int n_done;
      int first_done;
      start  = 1'b1;
      finish = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      finish     = 1'b0;
      model_addr = 32'h0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_wins_busy: got %b want 1", busy); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_wins_ready: got %b want 1", bus.in_ready); end
      close_session(n_done, first_done);
      checks++; if (n_done !== 1) begin errors++; $display("FAIL empty_done_pulses: got %0d want 1", n_done); end
      checks++; if (first_done !== 1) begin errors++; $display("FAIL empty_drain_cycle: got %0d want 1", first_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_encode_r_i_s();
      bit acc;
      int n_acc = 0;
      int n_done;
      int first_done;
      open_session();
      send_req(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b1, acc); n_acc += int'(acc);
      checks++; if (n_acc !== 4) begin errors++; $display("FAIL enc1_accepts: got %0d want 4", n_acc); end
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL enc1_full_ready: got %b want 0", bus.in_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL enc1_err: got %b want 0", err); end
      @(posedge clk);
      #1;
      close_session(n_done, first_done);
      checks++; if (n_done !== 1) begin errors++; $display("FAIL enc1_done: got %0d want 1", n_done); end
      checks++; if (words !== 16'd4) begin errors++; $display("FAIL enc1_words: got %0d want 4", words); end
   endtask

   task automatic test_encode_b_u_j_illegal();
      bit acc;
      int n_acc = 0;
      int n_done;
      int first_done;
      open_session();
      send_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b1, acc); n_acc += int'(acc);
      @(posedge clk);
      #1;
      send_req(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 1'b0, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL illegal_accept: got %b want 1", acc); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err); end
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL illegal_no_write: got %b want 0", bus.imem_we); end
      checks++; if (words !== 16'd1) begin errors++; $display("FAIL illegal_words: got %0d want 1", words); end
      @(posedge clk);
      #1;
      send_req(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0, 1'b0, acc);
      send_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd8, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd12, 32'h00C100E7, 1'b1, acc); n_acc += int'(acc);
      checks++; if (n_acc !== 4) begin errors++; $display("FAIL enc2_accepts: got %0d want 4", n_acc); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL enc2_err_sticky: got %b want 1", err); end
      close_session(n_done, first_done);
      checks++; if (words !== 16'd4) begin errors++; $display("FAIL enc2_words: got %0d want 4", words); end
   endtask

   task automatic test_stall();
      bit acc;
      int n_done;
      int first_done;
      open_session();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_clears_err: got %b want 0", err); end
      bus.imem_ready = 1'b0;
      send_req(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b1, acc);
      bus.in_valid = 1'b1;
      bus.in_cls   = 4'd1;
      bus.in_func3 = 3'd0;
      bus.in_rd    = 5'd1;
      bus.in_rs1   = 5'd0;
      bus.in_imm   = 32'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.in_ready); end
         checks++; if (bus.imem_we !== 1'b1) begin errors++; $display("FAIL stall_we[%0d]: got %b want 1", i, bus.imem_we); end
         checks++; if (bus.imem_wdata !== 32'h002081B3) begin errors++; $display("FAIL stall_wdata[%0d]: got %h want 002081b3", i, bus.imem_wdata); end
         checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 0", i, bus.imem_addr); end
         @(posedge clk);
         #1;
      end
      bus.imem_ready = 1'b1;
      send_req(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL stall_resume_accept: got %b want 1", acc); end
      close_session(n_done, first_done);
      checks++; if (words !== 16'd2) begin errors++; $display("FAIL stall_words: got %0d want 2", words); end
   endtask

   task automatic test_back_to_back();
      bit acc;
      int n_acc = 0;
      int base;
      int c0;
      int n_done;
      int first_done;
      open_session();
      base = rx_cyc_q.size();
      c0   = cyc;
      send_req(4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 32'h40315093, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd2, 3'd2, 1'b0, 5'd3, 5'd1, 5'd0, 32'hFFFF_FFFC, 32'hFFC0A183, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd6, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h0000_1000, 32'h00001117, 1'b1, acc); n_acc += int'(acc);
      send_req(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, acc); n_acc += int'(acc);
      checks++; if (n_acc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", n_acc); end
      checks++; if (cyc - c0 !== 4) begin errors++; $display("FAIL b2b_accept_cycles: got %0d want 4", cyc - c0); end
      close_session(n_done, first_done);
      checks++; if (rx_cyc_q.size() !== base + 4) begin
         errors++; $display("FAIL b2b_writes: got %0d want %0d", rx_cyc_q.size(), base + 4);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_cyc_q[base+i+1] !== rx_cyc_q[base+i] + 1) begin
               errors++;
               $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, rx_cyc_q[base+i+1], rx_cyc_q[base+i] + 1);
            end
         end
      end
   endtask

   task automatic test_full();
      bit acc;
      int n_acc = 0;
      int n_done;
      int first_done;
      logic [4:0] r;
      open_session();
      for (int i = 1; i <= 6; i++) begin
         r = 5'(i);
         send_req(4'd1, 3'd0, 1'b0, r, 5'd0, 5'd0, 32'(i), (32'(i) << 20) | (32'(i) << 7) | 32'h13,
                  1'b1, acc);
         n_acc += int'(acc);
      end
      checks++; if (n_acc !== 4) begin errors++; $display("FAIL full_accepts: got %0d want 4", n_acc); end
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL full_addr: got %h want 10", bus.imem_addr); end
      @(posedge clk);
      #1;
      close_session(n_done, first_done);
      checks++; if (n_done !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", n_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b want 0", busy); end
      checks++; if (words !== 16'd4) begin errors++; $display("FAIL full_words: got %0d want 4", words); end
   endtask

   task automatic test_reset_mid();
      bit acc;
      int n_rx;
      open_session();
      bus.imem_ready = 1'b0;
      send_req(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1, acc);
      checks++; if (bus.imem_we !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %b want 1", bus.imem_we); end
      // the pending word is discarded by reset
      if (acc) begin
         void'(exp_addr_q.pop_back());
         void'(exp_data_q.pop_back());
      end
      n_rx = rx_data_q.size();
      rst  = 1'b1;
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.imem_ready = 1'b1;
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", bus.imem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (bus.imem_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_wdata: got %h want 0", bus.imem_wdata); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", bus.imem_addr); end
      checks++; if (words !== 16'd0) begin errors++; $display("FAIL rstmid_words: got %0d want 0", words); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rx_data_q.size() !== n_rx) begin errors++; $display("FAIL rstmid_dropped: got %0d writes want %0d", rx_data_q.size(), n_rx); end
   endtask

   task automatic test_scoreboard();
      logic [31:0] ea, ed, ra, rd;
      checks++;
      if (rx_data_q.size() !== exp_data_q.size()) begin
         errors++;
         $display("FAIL sb_count: got %0d writes want %0d", rx_data_q.size(), exp_data_q.size());
      end
      while (rx_data_q.size() > 0 && exp_data_q.size() > 0) begin
         ea = exp_addr_q.pop_front();
         ed = exp_data_q.pop_front();
         ra = rx_addr_q.pop_front();
         rd = rx_data_q.pop_front();
         checks++; if (ra !== ea) begin errors++; $display("FAIL sb_addr: got %h want %h", ra, ea); end
         checks++; if (rd !== ed) begin errors++; $display("FAIL sb_data @%h: got %h want %h", ea, rd, ed); end
      end
   endtask

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      finish         = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_cls     = '0;
      bus.in_func3   = '0;
      bus.in_func7   = 1'b0;
      bus.in_rd      = '0;
      bus.in_rs1     = '0;
      bus.in_rs2     = '0;
      bus.in_imm     = '0;
      bus.imem_ready = 1'b1;
      test_reset();
      test_start_priority();
      test_encode_r_i_s();
      test_encode_b_u_j_illegal();
      test_stall();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_scoreboard();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
